sprite_line_renderer: RTL and testbench

- Per-scanline sprite stage between the host register interface and the double-buffered line buffer.
- Holds a 32-entry sprite attribute table, written by the host.
- On each start pulse it finds the sprites that intersect the next scanline and fetches their 16x16 pixel rows from sprite ROM.
- Non-transparent pixels go into the draw bank of the line buffer, overlaying the tile layer the tile stage has already written.

---
 rtl/sprite_line_renderer.sv | 204 ++++++++++++++++++++
 tb/tb_sprite_line_renderer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - per-scanline sprite stage; optional vertical flip under SPRITE_VFLIP_EN
module sprite_line_renderer #(
    parameter int NUM_SPR = 32,
    parameter int LINE_W  = 640,
    parameter int V_LAST  = 524
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sprite_start,
    input  logic [9:0]  vcount,
    input  logic        spr_wr_en,
    input  logic [4:0]  spr_wr_idx,
    input  logic [31:0] spr_wr_data,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [9:0]  sprite_pixel_col,
    output logic [15:0] sprite_pixel_data,
    output logic        wren_pixel_draw,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    // Attribute table
    logic [31:0] tbl_q [NUM_SPR];

    // Render control
    logic [9:0]  tgt_q;
    logic [4:0]  idx_q;
    logic [3:0]  cnt_q;
    logic        done_q;

    // Working copy of the sprite being fetched, isolated from host writes
    logic [7:0]  w_frame_q;
    logic [3:0]  w_row_q;
    logic        w_hflip_q;
    logic [9:0]  w_x_q;

    // One-stage write pipeline aligned with ROM read latency
    logic        pipe_valid_q;
    logic [10:0] pipe_col_q;

    // Scan-time combinational values
    logic [31:0] cur_attr;
    logic [9:0]  row_full;
    logic [3:0]  row_sel;
    logic        hit;
    logic [9:0]  tgt_next;

    // Host writes land in the table one cycle after the strobe; reset disables every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (spr_wr_en) begin
            tbl_q[spr_wr_idx] <= spr_wr_data;
        end
    end

    // Hit test for the entry under scan; the row difference wraps in 10 bits on purpose
    always_comb begin
        cur_attr = tbl_q[idx_q];
        row_full = tgt_q - cur_attr[19:10];
        hit      = cur_attr[31] && (row_full[9:4] == 6'd0);
`ifdef SPRITE_VFLIP_EN
        row_sel  = cur_attr[9] ? (4'd15 - row_full[3:0]) : row_full[3:0];
`else
        row_sel  = row_full[3:0];
`endif
        tgt_next = (vcount == 10'(V_LAST)) ? 10'd0 : vcount + 10'd1;
    end

`ifdef SPRITE_VFLIP_EN
    logic unused_attr_bits;
    assign unused_attr_bits = cur_attr[8];
`else
    logic unused_attr_bits;
    assign unused_attr_bits = ^cur_attr[9:8];
`endif

    // State register; reset aborts any render in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: scan entries high to low, fetch 16 pixels per hit, drain the last write
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sprite_start) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    state_d = S_FETCH;
                end else if (idx_q == 5'd0) begin
                    state_d = S_FIN;
                end
            end
            S_FETCH: begin
                if (cnt_q == 4'd15) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = (idx_q == 5'd0) ? S_FIN : S_SCAN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Render datapath: target line, entry index, pixel counter, working copy and done level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b1;
            w_frame_q <= '0;
            w_row_q   <= '0;
            w_hflip_q <= 1'b0;
            w_x_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sprite_start) begin
                        tgt_q  <= tgt_next;
                        idx_q  <= 5'(NUM_SPR - 1);
                        done_q <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        cnt_q     <= 4'd0;
                        w_frame_q <= cur_attr[7:0];
                        w_row_q   <= row_sel;
                        w_hflip_q <= cur_attr[30];
                        w_x_q     <= cur_attr[29:20];
                    end else if (idx_q != 5'd0) begin
                        idx_q <= idx_q - 5'd1;
                    end
                end
                S_FETCH: begin
                    cnt_q <= cnt_q + 4'd1;
                end
                S_DRAIN: begin
                    if (idx_q != 5'd0) begin
                        idx_q <= idx_q - 5'd1;
                    end
                end
                S_FIN: begin
                    done_q <= 1'b1;
                end
                default: begin
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    // Carry each fetch's column forward one cycle to meet the ROM data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_q <= 1'b0;
            pipe_col_q   <= '0;
        end else begin
            pipe_valid_q <= (state_q == S_FETCH);
            pipe_col_q   <= {1'b0, w_x_q} + {7'd0, cnt_q};
        end
    end

    // Outputs: ROM address during fetch, clipped and transparency-masked line buffer write
    always_comb begin
        rom_addr = 16'd0;
        if (state_q == S_FETCH) begin
            rom_addr = {w_frame_q, w_row_q, (w_hflip_q ? ~cnt_q : cnt_q)};
        end
        wren_pixel_draw   = pipe_valid_q && !rom_data[15] && (pipe_col_q < 11'(LINE_W));
        sprite_pixel_data = pipe_valid_q ? rom_data : 16'd0;
        sprite_pixel_col  = pipe_col_q[9:0];
        done              = done_q;
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb/tb_sprite_line_renderer.sv - directed table-driven bench for sprite_line_renderer
`timescale 1ns/1ps
module tb_sprite_line_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sprite_start;
    logic [9:0]  vcount;
    logic        spr_wr_en;
    logic [4:0]  spr_wr_idx;
    logic [31:0] spr_wr_data;
    logic [15:0] rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic [9:0]  sprite_pixel_col;
    logic [15:0] sprite_pixel_data;
    logic        wren_pixel_draw;
    logic        done;

    logic [15:0] trans_addr = 16'hFFFF;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wr_col [$];
    logic [15:0] wr_dat [$];

    sprite_line_renderer dut (
        .clk               (clk),
        .reset             (reset),
        .sprite_start      (sprite_start),
        .vcount            (vcount),
        .spr_wr_en         (spr_wr_en),
        .spr_wr_idx        (spr_wr_idx),
        .spr_wr_data       (spr_wr_data),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .sprite_pixel_col  (sprite_pixel_col),
        .sprite_pixel_data (sprite_pixel_data),
        .wren_pixel_draw   (wren_pixel_draw),
        .done              (done)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] rom_pix(input logic [15:0] a, input logic [15:0] t);
        return {(a == t), a[14:0] ^ 15'h5A5A};
    endfunction

    // Synchronous ROM model: data one cycle after address
    always @(posedge clk) rom_data <= rom_pix(rom_addr, trans_addr);

    // Line buffer write capture
    always @(negedge clk) begin
        if (!reset && wren_pixel_draw) begin
            wr_col.push_back(sprite_pixel_col);
            wr_dat.push_back(sprite_pixel_data);
        end
    end

    function automatic logic [31:0] mk(input logic en, input logic hf, input int x, input int y,
                                       input int fr, input logic vf);
        return {en, hf, 10'(x), 10'(y), vf, 1'b0, 8'(fr)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wr_attr(input int idx, input logic [31:0] data);
        @(negedge clk);
        spr_wr_en   = 1'b1;
        spr_wr_idx  = 5'(idx);
        spr_wr_data = data;
        @(negedge clk);
        spr_wr_en   = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 32; i++) wr_attr(i, 32'd0);
    endtask

    // Start a render and count negedges with done low; optionally rewrite entry 0 mid-render
    task automatic render(input int vc, input int mid_at, input logic [31:0] mid_attr, output int lo);
        bit fired;
        fired = 1'b0;
        wr_col.delete();
        wr_dat.delete();
        @(negedge clk);
        vcount       = 10'(vc);
        sprite_start = 1'b1;
        @(negedge clk);
        sprite_start = 1'b0;
        lo = 0;
        while (done == 1'b0 && lo < 2000) begin
            lo++;
            spr_wr_en = 1'b0;
            if (mid_at >= 0 && !fired && wr_col.size() >= mid_at) begin
                fired       = 1'b1;
                spr_wr_en   = 1'b1;
                spr_wr_idx  = 5'd0;
                spr_wr_data = mid_attr;
            end
            @(negedge clk);
        end
        spr_wr_en = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] attr;
        int          vc;
        logic [15:0] trans;
        int          n_wr;
        int          lo;
        int          c0;
        logic [15:0] a0;
        int          c2;
        int          cl;
        logic [15:0] al;
    } vec_t;

`ifdef SPRITE_VFLIP_EN
    localparam logic [3:0] VROW = 4'd12;
`else
    localparam logic [3:0] VROW = 4'd3;
`endif

    initial begin
        vec_t vecs [9];
        int   lo;

        vecs[0] = '{0, mk(0,0,0,0,0,0),       10,  16'hFFFF, 0,  33, 0,   16'h0,    0,   0,   16'h0};
        vecs[1] = '{0, mk(1,0,100,50,2,0),    52,  16'hFFFF, 16, 50, 100, 16'h0230, 102, 115, 16'h023F};
        vecs[2] = '{0, mk(1,1,100,50,2,0),    52,  16'hFFFF, 16, 50, 100, 16'h023F, 102, 115, 16'h0230};
        vecs[3] = '{3, mk(1,0,630,0,7,0),     524, 16'hFFFF, 10, 50, 630, 16'h0700, 632, 639, 16'h0709};
        vecs[4] = '{3, mk(1,0,630,0,7,0),     524, 16'h0702, 9,  50, 630, 16'h0700, 633, 639, 16'h0709};
        vecs[5] = '{7, mk(0,0,5,11,3,0),      10,  16'hFFFF, 0,  33, 0,   16'h0,    0,   0,   16'h0};
        vecs[6] = '{9, mk(1,0,0,1020,4,0),    1,   16'hFFFF, 16, 50, 0,   16'h0460, 2,   15,  16'h046F};
        vecs[7] = '{9, mk(1,0,0,50,4,0),      65,  16'hFFFF, 0,  33, 0,   16'h0,    0,   0,   16'h0};
        vecs[8] = '{0, mk(1,0,20,50,2,1),     52,  16'hFFFF, 16, 50, 20,  {8'h02, VROW, 4'h0}, 22, 35, {8'h02, VROW, 4'hF}};

        reset        = 1'b1;
        sprite_start = 1'b0;
        vcount       = 10'd0;
        spr_wr_en    = 1'b0;
        spr_wr_idx   = 5'd0;
        spr_wr_data  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_wren", 32'(wren_pixel_draw), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_col", 32'(sprite_pixel_col), 32'd0);
        chk("rst_data", 32'(sprite_pixel_data), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            clear_all();
            wr_attr(vecs[i].idx, vecs[i].attr);
            trans_addr = vecs[i].trans;
            render(vecs[i].vc, -1, 32'd0, lo);
            chk($sformatf("v%0d_done_low", i), 32'(lo), 32'(vecs[i].lo));
            chk($sformatf("v%0d_nwr", i), 32'(wr_col.size()), 32'(vecs[i].n_wr));
            if (vecs[i].n_wr > 2 && wr_col.size() == vecs[i].n_wr) begin
                chk($sformatf("v%0d_col0", i), 32'(wr_col[0]), 32'(vecs[i].c0));
                chk($sformatf("v%0d_dat0", i), 32'(wr_dat[0]), 32'(rom_pix(vecs[i].a0, vecs[i].trans)));
                chk($sformatf("v%0d_col2", i), 32'(wr_col[2]), 32'(vecs[i].c2));
                chk($sformatf("v%0d_coll", i), 32'(wr_col[vecs[i].n_wr-1]), 32'(vecs[i].cl));
                chk($sformatf("v%0d_datl", i), 32'(wr_dat[vecs[i].n_wr-1]), 32'(rom_pix(vecs[i].al, vecs[i].trans)));
            end
        end

        // Priority: sprite 5 drawn first, sprite 0 last; entry 0 rewritten mid-row
        trans_addr = 16'hFFFF;
        clear_all();
        wr_attr(0, mk(1,0,200,20,1,0));
        wr_attr(5, mk(1,0,200,20,5,0));
        render(20, 18, mk(1,0,300,20,9,0), lo);
        chk("prio_done_low", 32'(lo), 32'd67);
        chk("prio_nwr", 32'(wr_col.size()), 32'd32);
        if (wr_col.size() == 32) begin
            chk("prio_s5_col0", 32'(wr_col[0]), 32'd200);
            chk("prio_s5_dat0", 32'(wr_dat[0]), 32'(rom_pix(16'h0510, 16'hFFFF)));
            chk("prio_s5_datl", 32'(wr_dat[15]), 32'(rom_pix(16'h051F, 16'hFFFF)));
            chk("prio_s0_col0", 32'(wr_col[16]), 32'd200);
            chk("prio_s0_dat0", 32'(wr_dat[16]), 32'(rom_pix(16'h0110, 16'hFFFF)));
            chk("prio_s0_coll", 32'(wr_col[31]), 32'd215);
            chk("prio_s0_datl", 32'(wr_dat[31]), 32'(rom_pix(16'h011F, 16'hFFFF)));
        end
        render(20, -1, 32'd0, lo);
        chk("upd_nwr", 32'(wr_col.size()), 32'd32);
        if (wr_col.size() == 32) begin
            chk("upd_s0_col0", 32'(wr_col[16]), 32'd300);
            chk("upd_s0_dat0", 32'(wr_dat[16]), 32'(rom_pix(16'h0910, 16'hFFFF)));
        end

        // Reset during FETCH: outputs drop asynchronously, table is cleared
        clear_all();
        wr_attr(0, mk(1,0,100,50,2,0));
        @(negedge clk);
        vcount       = 10'd52;
        sprite_start = 1'b1;
        @(negedge clk);
        sprite_start = 1'b0;
        begin
            int wait_cyc;
            wait_cyc = 0;
            while (!wren_pixel_draw && wait_cyc < 200) begin
                wait_cyc++;
                @(negedge clk);
            end
            chk("rstmid_reached_fetch", 32'(wren_pixel_draw), 32'd1);
        end
        #3 reset = 1'b1;
        #1;
        chk("rstmid_done", 32'(done), 32'd1);
        chk("rstmid_wren", 32'(wren_pixel_draw), 32'd0);
        chk("rstmid_rom_addr", 32'(rom_addr), 32'd0);
        chk("rstmid_col", 32'(sprite_pixel_col), 32'd0);
        chk("rstmid_data", 32'(sprite_pixel_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        render(52, -1, 32'd0, lo);
        chk("post_rst_done_low", 32'(lo), 32'd33);
        chk("post_rst_nwr", 32'(wr_col.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
